// File: rtl/xdma_c2h_chan_mux.sv
// Round-robin packet multiplexer from NUM_CH capture streams into the XDMA C2H channel-0 stream.
// Optionally prefixes each packet with a channel/sequence header beat, and splits packets at MAX_BEATS.
module xdma_c2h_chan_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int HDR_EN     = 1,
  parameter int MAX_BEATS  = 256
) (
  input  logic                         user_clk,
  input  logic                         user_reset,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_c2h_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_c2h_tkeep,
  output logic                         m_axis_c2h_tlast,
  output logic                         m_axis_c2h_tvalid,
  input  logic                         m_axis_c2h_tready,
  output logic                         busy,
  output logic [15:0]                  split_cnt
);

  localparam int          KW  = DATA_WIDTH / 8;
  localparam int          CW  = $clog2(NUM_CH);
  localparam int unsigned NCH = NUM_CH;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t state, state_nxt;

  // grant doubles as last_grant: it holds the most recent winner between packets
  logic [CW-1:0]         grant;
  logic [CW-1:0]         pick;
  logic [CW-1:0]         idx;
  logic                  pick_vld;
  logic [31:0]           seq [NUM_CH];
  logic [15:0]           beat_cnt;
  logic                  out_free;
  logic                  in_fire;
  logic                  at_limit;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] hdr_word;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [KW-1:0]         ch_keep [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign ch_keep[i] = s_axis_tkeep[i*KW +: KW];
  end

  assign out_free = !m_axis_c2h_tvalid || m_axis_c2h_tready;
  assign in_fire  = (state == DATA) && s_axis_tvalid[grant] && out_free;
  assign at_limit = (beat_cnt == 16'(MAX_BEATS - 1));
  assign sel_last = s_axis_tlast[grant] || at_limit;

  // Round-robin search starting one past the previous winner
  always_comb begin
    pick     = grant;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = CW'((32'(grant) + k) % NCH);
      if (!pick_vld && s_axis_tvalid[idx] && ch_enable[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    hdr_word         = '0;
    hdr_word[63:56]  = 8'hA5;
    hdr_word[55:48]  = 8'(grant);
    hdr_word[31:0]   = seq[grant];
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = (HDR_EN != 0) ? HDR : DATA;
      HDR:  if (out_free) state_nxt = DATA;
      DATA: if (in_fire && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state == DATA) s_axis_tready[grant] = out_free;
    busy = (state != IDLE);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      grant             <= CW'(NUM_CH - 1);
      beat_cnt          <= '0;
      split_cnt         <= '0;
      m_axis_c2h_tdata  <= '0;
      m_axis_c2h_tkeep  <= '0;
      m_axis_c2h_tlast  <= 1'b0;
      m_axis_c2h_tvalid <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) seq[i] <= '0;
    end else begin
      if (state == IDLE && pick_vld) grant <= pick;

      // A new beat takes priority over retiring the accepted one, keeping DATA bubble-free
      if (state == HDR && out_free) begin
        m_axis_c2h_tdata  <= hdr_word;
        m_axis_c2h_tkeep  <= '1;
        m_axis_c2h_tlast  <= 1'b0;
        m_axis_c2h_tvalid <= 1'b1;
      end else if (in_fire) begin
        m_axis_c2h_tdata  <= ch_data[grant];
        m_axis_c2h_tkeep  <= ch_keep[grant];
        m_axis_c2h_tlast  <= sel_last;
        m_axis_c2h_tvalid <= 1'b1;
      end else if (m_axis_c2h_tready) begin
        m_axis_c2h_tvalid <= 1'b0;
      end

      if (in_fire) begin
        if (sel_last) begin
          beat_cnt    <= '0;
          seq[grant]  <= seq[grant] + 32'd1;
          if (at_limit && !s_axis_tlast[grant] && split_cnt != 16'hFFFF)
            split_cnt <= split_cnt + 16'd1;
        end else begin
          beat_cnt <= beat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/xdma_c2h_chan_mux.md
# xdma_c2h_chan_mux

Parametrised N-channel AXI4-Stream packet multiplexer feeding the XDMA C2H channel-0 stream (`s_axis_c2h_*` of the PCIe endpoint top) in the `user_clk` domain.

- Arbitrates whole packets from NUM_CH multiline capture channels, round-robin.
- Optionally prefixes each packet with a header word carrying the channel ID and a per-channel sequence number.
- Splits over-long packets at MAX_BEATS.
- Replaces the earlier single-channel direct connection of user logic to C2H.

## Interface

Parameters:
- DATA_WIDTH, 64: stream width in bits. Must be ≥ 64 and a multiple of 8.
- NUM_CH, 4: number of input channels, 2..16.
- HDR_EN, 1: 1 inserts a header beat per packet; 0 passes packets through unmodified.
- MAX_BEATS, 256: maximum data beats per output packet, 1..65535.

Ports:
- user_clk, in, 1: XDMA `axi_aclk`; the only clock.
- user_reset, in, 1: synchronous, active-high reset.
- ch_enable, in, NUM_CH: per-channel arbitration enable.
- s_axis_tdata, in, NUM_CH*DATA_WIDTH: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep, in, NUM_CH*DATA_WIDTH/8: same packing as tdata.
- s_axis_tlast, in, NUM_CH: per-channel tlast.
- s_axis_tvalid, in, NUM_CH: per-channel tvalid.
- s_axis_tready, out, NUM_CH: per-channel tready.
- m_axis_c2h_tdata, out, DATA_WIDTH: to XDMA `s_axis_c2h_tdata_0`.
- m_axis_c2h_tkeep, out, DATA_WIDTH/8: output tkeep.
- m_axis_c2h_tlast, out, 1: output tlast.
- m_axis_c2h_tvalid, out, 1: output tvalid.
- m_axis_c2h_tready, in, 1: output tready.
- busy, out, 1: high when the FSM is not in IDLE.
- split_cnt, out, 16: count of forced packet splits; saturates at 16'hFFFF.

## Operation

**FSM states.** IDLE, HDR, DATA.

**IDLE.**
- A channel is eligible when s_axis_tvalid[i] & ch_enable[i].
- Search starts at (last_grant+1) mod NUM_CH and takes the first eligible channel. last_grant resets to NUM_CH-1, so channel 0 has first priority after reset.
- On a grant: latch grant and set last_grant = grant.
- Next state is HDR if HDR_EN=1, otherwise DATA.
- With no eligible channel, remain in IDLE.

**HDR.**
- When the output register is free, load a header beat with tkeep all ones and tlast=0, then go to DATA.
- Header layout:
  - [63:56] = 8'hA5
  - [55:48] = channel ID (zero-extended)
  - [47:32] = 0
  - [31:0] = seq[grant]
  - bits above 63 = 0

**DATA.**
- s_axis_tready[grant] = out_free. All other tready bits are 0.
- Each accepted beat is copied with tdata/tkeep unmodified.
- Output tlast = s_axis_tlast[grant] | (beat_cnt == MAX_BEATS-1).
- After the last beat is accepted:
  - seq[grant] increments, wrapping 32'hFFFFFFFF→0.
  - beat_cnt clears.
  - next state is IDLE.
- If the terminating condition was the MAX_BEATS limit and the input tlast was 0, split_cnt increments. The remainder of the input packet is re-arbitrated as a new packet with a new header and the next sequence number.

**Output register.**
- One stage; out_free = !m_axis_c2h_tvalid | m_axis_c2h_tready.
- It loads a new beat on the same edge that the previous beat is accepted, so there are no bubbles within DATA.

**ch_enable timing.**
- Sampled only in IDLE.
- Deasserting ch_enable for the granted channel mid-packet has no effect until the packet ends.

**Reset (user_reset=1 on an edge).**
- FSM → IDLE.
- All seq counters = 0; beat_cnt = 0; split_cnt = 0.
- An in-flight packet is abandoned without tlast. Downstream must also be reset.

**Output reset values.**
- m_axis_c2h_tvalid = 0, tlast = 0, tdata = 0, tkeep = 0.
- s_axis_tready = 0.
- busy = 0.
- split_cnt = 0.

## Timing

- Latency from an input tvalid rising in IDLE with the output idle and tready=1:
  - HDR_EN=1: grant at edge 1; header valid after edge 2; first data beat valid after edge 3.
  - HDR_EN=0: grant at edge 1; first data beat valid after edge 2.
- Throughput within a packet: 1 beat/cycle while m_axis_c2h_tready=1.
- Packet-to-packet gap: 1 IDLE cycle, plus 1 HDR cycle when HDR_EN=1.
- AXI-S rules:
  - m_axis_c2h_tvalid/tdata/tkeep/tlast hold stable while tvalid=1 & tready=0.
  - tvalid never depends combinationally on tready.
  - s_axis_tready depends combinationally on m_axis_c2h_tready through out_free; this is the only combinational path.
- Simultaneous events:
  - Output acceptance and a new beat load on the same edge: the new beat wins; tvalid stays 1.
  - Input tlast on beat MAX_BEATS: a normal end, no split count.
- beat_cnt width: 16 bits. Compared against MAX_BEATS-1.

## Test plan

1. **Single packet, header on.** NUM_CH=4, HDR_EN=1. Ch2 sends 3 beats (0x11,0x22,0x33) with tready=1.
   - Output: A502_0000_0000_0000, then 0x11, 0x22, 0x33 with tlast on the 4th beat.
   - Header visible 2 cycles after tvalid.
   - Second packet header carries seq=1.
2. **Round-robin.** All 4 channels continuously valid with 2-beat packets.
   - Grant order 0,1,2,3,0…
   - No channel is granted twice before every other eligible channel has been granted once.
3. **Forced split.** MAX_BEATS=4. Ch1 sends a 10-beat packet.
   - Output packets of 4, 4 and 2 data beats, each with its own header, seq 0,1,2.
   - split_cnt=2.
4. **Backpressure.** Random m_axis_c2h_tready at 30% duty.
   - Output stable while stalled.
   - No beat lost or duplicated; scoreboard matches the input streams.
   - s_axis_tready is 0 for all non-granted channels.
5. **Reset mid-packet and disabled channel.**
   - Assert user_reset during beat 2 of a ch3 packet: next cycle tvalid=0, busy=0, seq[3]=0.
   - With ch_enable[0]=0 and ch0 valid: ch0 is never granted.
6. **Pass-through mode.** HDR_EN=0. Ch0 sends 5 beats with tkeep=0x0F on the last beat.
   - Output is identical, with no header.
   - First beat appears 2 cycles after tvalid.
